cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Transmit side of the common data bus (CDB) into the ROB. Each functional unit (FU) pushes a
//  finished result, tagged with its ROB index, into a small per-source FIFO. Every cycle the block
//  grants up to 4 results round-robin and drives registered cdb_valid/indices/values slots.
//  These slots feed the ROB's 4-slot completion port and the reservation stations.
// PARAMETERS
//  NUM_SRC     6   number of FU result sources (2..8)
//  FIFO_DEPTH  2   entries per source FIFO (power of 2, >=2)
//  TAG_W       4   ROB index width (16-entry ROB)
//  DATA_W      16  result width
// PORTS
//  clk              in   1               rising-edge clock
//  rst_n            in   1               synchronous reset, active-low
//  flush            in   1               squash: drop all pending results
//  src_valid_flat   in   NUM_SRC         per-source result valid
//  src_ready_flat   out  NUM_SRC         per-source FIFO can accept
//  src_tag_flat     in   NUM_SRC*TAG_W   per-source ROB index
//  src_data_flat    in   NUM_SRC*DATA_W  per-source result value
//  cdb_valid_flat   out  4               CDB slot valid
//  indices_flat     out  4*TAG_W         CDB slot ROB index
//  new_values_flat  out  4*DATA_W        CDB slot value
// BEHAVIOUR
//  - Flat packing: element k of a W-wide flat bus occupies bits [W*(N-1-k)+W-1 : W*(N-1-k)], so
//    element 0 sits in the MSBs. This applies to sources (N=NUM_SRC) and to slots (N=4).
//  - Reset (rst_n=0 at posedge): FIFOs empty, rr_ptr=0, all CDB outputs 0.
//    src_ready_flat=0 while rst_n=0. Nothing is accepted in a reset cycle.
//  - Push: a source is accepted at a posedge when src_valid[k] && src_ready[k].
//    src_ready[k] = rst_n && (count[k] != FIFO_DEPTH). Ready depends only on registered count,
//    not on a same-cycle pop.
//  - Arbitration: combinational scan of sources starting at rr_ptr, wrapping mod NUM_SRC.
//    Each non-empty source contributes its FIFO head. At most 1 grant per source and 4 grants
//    per cycle. Granted entries fill slots 0,1,2,... in scan order, compacted with no holes.
//  - Output: slots are registered at the posedge. Unused slots drive valid=0, tag=0, data=0.
//    Each CDB output is valid for exactly one cycle, and the ROB has no backpressure.
//  - rr_ptr: <= (last granted source + 1) mod NUM_SRC; unchanged if there are no grants.
//  - Pop and push on the same source in one cycle are both legal. count is unchanged; rd/wr
//    pointers wrap at FIFO_DEPTH.
//  - Latency without bypass: accepted at edge t, earliest on CDB after edge t+1.
//  - Ordering: per source, FIFO order is preserved. Across sources there is no ordering guarantee.
//  - Tags are not checked. Duplicate tags are broadcast as given.
//  - flush=1 at posedge: all FIFOs are emptied, inputs that cycle are dropped, rr_ptr=0,
//    CDB outputs are 0 next cycle. flush has lower priority than reset.
//  - Reset or flush mid-stream: pending entries are never broadcast.
// CONFIGURATION
//  CDB_BYPASS_EN defined: a source with an empty FIFO and src_valid=1 (and src_ready=1) joins
//    arbitration in the same cycle with its input as head. If granted, it goes straight to the
//    output registers at edge t (1-cycle latency) and is not written to the FIFO. If not
//    granted, it is pushed normally.
//  CDB_BYPASS_EN undefined: inputs always go through the FIFO (2-edge latency, as above).
// TESTING (NUM_SRC=6, FIFO_DEPTH=2, bypass off unless stated)
//  1. Reset: rst_n=0 for 2 cycles with all src_valid=1 -> src_ready=0, cdb_valid_flat=0;
//     after release no stale data appears.
//  2. Single result: src2 pushes tag 5, data 16'h1234 at edge t -> after edge t+1
//     cdb_valid_flat=4'b1000, indices_flat[15:12]=5, new_values_flat[63:48]=16'h1234,
//     other bits 0, for one cycle only.
//  3. Burst: srcs 0..5 push tags 0..5 in one cycle -> first broadcast tags {0,1,2,3},
//     valid=4'b1111; next broadcast tags {4,5} in slots 0,1, valid=4'b1100; then valid=0.
//  4. Fairness/backpressure: all 6 sources valid every cycle -> grants rotate {0-3},{4,5,0,1},
//     {2-5}. Each source receives 2 grants per 3 cycles, FIFOs fill and src_ready drops. A
//     scoreboard shows no drops, no duplicates, and per-source order kept.
//  5. Flush: 4 entries pending, pulse flush -> next cycle cdb_valid_flat=0 and src_ready all 1;
//     the flushed tags never appear on the CDB.
//  6. With CDB_BYPASS_EN: repeat test 2 -> result appears after edge t (1 cycle earlier).
//     Repeat test 3 -> tags {0,1,2,3} after edge t, {4,5} after edge t+1.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus transmit arbiter: per-source result FIFOs, round-robin grant of up to 4 results/cycle.
// Optional same-cycle bypass of empty FIFOs when CDB_BYPASS_EN is defined.
module cdb_arbiter #(
  parameter int NUM_SRC    = 6,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 4,
  parameter int DATA_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid_flat,
  output logic [NUM_SRC-1:0]        src_ready_flat,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag_flat,
  input  logic [NUM_SRC*DATA_W-1:0] src_data_flat,
  output logic [3:0]                cdb_valid_flat,
  output logic [4*TAG_W-1:0]        indices_flat,
  output logic [4*DATA_W-1:0]       new_values_flat
);

  localparam int SLOTS = 4;
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0]  tag_mem  [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr   [NUM_SRC];
  logic [PTR_W-1:0]  wr_ptr   [NUM_SRC];
  logic [CNT_W-1:0]  count    [NUM_SRC];
  logic [SRC_W-1:0]  rr_ptr;

  logic [NUM_SRC-1:0] in_valid, ready, push, cand, grant, pop, wr_en;
  logic [TAG_W-1:0]   in_tag    [NUM_SRC];
  logic [TAG_W-1:0]   head_tag  [NUM_SRC];
  logic [DATA_W-1:0]  in_data   [NUM_SRC];
  logic [DATA_W-1:0]  head_data [NUM_SRC];

  logic [3:0]         slot_valid;
  logic [TAG_W-1:0]   slot_tag  [SLOTS];
  logic [DATA_W-1:0]  slot_data [SLOTS];
  logic [SRC_W-1:0]   last_src;
  logic               any_grant;

  // Element 0 of every flat bus lives in the MSBs.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      in_valid[k] = src_valid_flat[NUM_SRC-1-k];
      in_tag[k]   = src_tag_flat[TAG_W*(NUM_SRC-1-k) +: TAG_W];
      in_data[k]  = src_data_flat[DATA_W*(NUM_SRC-1-k) +: DATA_W];
      ready[k]    = rst_n && (count[k] != CNT_W'(FIFO_DEPTH));
      src_ready_flat[NUM_SRC-1-k] = ready[k];
      push[k]     = in_valid[k] && ready[k];
`ifdef CDB_BYPASS_EN
      cand[k]     = (count[k] != '0) || push[k];
`else
      cand[k]     = (count[k] != '0);
`endif
      head_tag[k]  = (count[k] != '0) ? tag_mem[k][rd_ptr[k]]  : in_tag[k];
      head_data[k] = (count[k] != '0) ? data_mem[k][rd_ptr[k]] : in_data[k];
    end
  end

  // Scan from rr_ptr, packing granted heads into slots 0..3 with no holes.
  always_comb begin
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] idx;
    logic [2:0]       n_grant;
    sum        = '0;
    idx        = '0;
    n_grant    = '0;
    grant      = '0;
    slot_valid = '0;
    last_src   = '0;
    any_grant  = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      slot_tag[s]  = '0;
      slot_data[s] = '0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      sum = {1'b0, rr_ptr} + (SRC_W+1)'(i);
      if (sum >= (SRC_W+1)'(NUM_SRC)) sum = sum - (SRC_W+1)'(NUM_SRC);
      idx = sum[SRC_W-1:0];
      if (cand[idx] && (n_grant < 3'd4)) begin
        grant[idx]                = 1'b1;
        slot_valid[n_grant[1:0]]  = 1'b1;
        slot_tag[n_grant[1:0]]    = head_tag[idx];
        slot_data[n_grant[1:0]]   = head_data[idx];
        last_src                  = idx;
        any_grant                 = 1'b1;
        n_grant                   = n_grant + 3'd1;
      end
    end
  end

  // A grant on an empty FIFO is a bypass: the input goes out directly and is never stored.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      pop[k]   = grant[k] && (count[k] != '0);
      wr_en[k] = push[k] && !(grant[k] && (count[k] == '0));
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SRC; k++) begin
      if (rst_n && !flush && wr_en[k]) begin
        tag_mem[k][wr_ptr[k]]  <= in_tag[k];
        data_mem[k][wr_ptr[k]] <= in_data[k];
      end
    end
  end

  // Flush clears exactly the state reset clears; reset still wins by being checked first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        count[k]  <= '0;
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
      end
      rr_ptr          <= '0;
      cdb_valid_flat  <= '0;
      indices_flat    <= '0;
      new_values_flat <= '0;
    end else if (flush) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        count[k]  <= '0;
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
      end
      rr_ptr          <= '0;
      cdb_valid_flat  <= '0;
      indices_flat    <= '0;
      new_values_flat <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (pop[k])   rd_ptr[k] <= rd_ptr[k] + 1'b1;
        if (wr_en[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        count[k] <= count[k] + CNT_W'(wr_en[k]) - CNT_W'(pop[k]);
      end
      if (any_grant)
        rr_ptr <= (last_src == SRC_W'(NUM_SRC-1)) ? '0 : last_src + 1'b1;
      for (int s = 0; s < SLOTS; s++) begin
        cdb_valid_flat[SLOTS-1-s]                     <= slot_valid[s];
        indices_flat[TAG_W*(SLOTS-1-s) +: TAG_W]      <= slot_tag[s];
        new_values_flat[DATA_W*(SLOTS-1-s) +: DATA_W] <= slot_data[s];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (6 sources, depth-2 FIFOs).
// Latency-dependent expectations follow CDB_BYPASS_EN when the bench is built with it.
module tb_cdb_arbiter;

  localparam int NS = 6;
  localparam int TW = 4;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [NS-1:0]     src_valid_flat;
  logic [NS-1:0]     src_ready_flat;
  logic [NS*TW-1:0]  src_tag_flat;
  logic [NS*DW-1:0]  src_data_flat;
  logic [3:0]        cdb_valid_flat;
  logic [4*TW-1:0]   indices_flat;
  logic [4*DW-1:0]   new_values_flat;

  int total = 0;
  int bad   = 0;
  int pushed [NS];
  int recv   [NS];

  logic [5:0]  rdy_pat [3] = '{6'h3C, 6'h33, 6'h0F};
  logic [15:0] idx_pat [3] = '{16'h0123, 16'h4501, 16'h2345};

  cdb_arbiter #(
    .NUM_SRC(NS), .FIFO_DEPTH(2), .TAG_W(TW), .DATA_W(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .src_valid_flat(src_valid_flat),
    .src_ready_flat(src_ready_flat),
    .src_tag_flat(src_tag_flat),
    .src_data_flat(src_data_flat),
    .cdb_valid_flat(cdb_valid_flat),
    .indices_flat(indices_flat),
    .new_values_flat(new_values_flat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic set_src(input int k, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
    src_valid_flat[NS-1-k]          = v;
    src_tag_flat[TW*(NS-1-k) +: TW] = t;
    src_data_flat[DW*(NS-1-k) +: DW] = d;
  endtask

  task automatic clear_srcs();
    src_valid_flat = '0;
    src_tag_flat   = '0;
    src_data_flat  = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_output("flush_idle", 64'(cdb_valid_flat), 64'h0);
  endtask

  // Each valid slot must carry the next in-order sequence number of the source named by its tag.
  task automatic score_slots();
    logic [TW-1:0] t;
    logic [DW-1:0] d;
    for (int s = 0; s < 4; s++) begin
      if (cdb_valid_flat[3-s]) begin
        t = indices_flat[TW*(3-s) +: TW];
        d = new_values_flat[DW*(3-s) +: DW];
        if (int'(t) < NS) begin
          check_output("sb_order", 64'(d), 64'({t, 12'(recv[t])}));
          recv[t]++;
        end else begin
          check_output("sb_tag_range", 64'(t), 64'(NS - 1));
        end
      end
    end
  endtask

  initial begin
    logic [NS-1:0] acc;
    rst_n = 1'b0;
    flush = 1'b0;
    for (int k = 0; k < NS; k++) begin
      set_src(k, 1'b1, TW'(k + 7), DW'(16'hBEE0 + k));
      pushed[k] = 0;
      recv[k]   = 0;
    end

    // Reset held with all sources valid: nothing accepted, nothing broadcast.
    #1;
    check_output("rst_ready_pre", 64'(src_ready_flat), 64'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check_output("rst_ready", 64'(src_ready_flat), 64'h0);
      check_output("rst_valid", 64'(cdb_valid_flat), 64'h0);
      check_output("rst_values", new_values_flat, 64'h0);
    end
    rst_n = 1'b1;
    clear_srcs();
    #1;
    check_output("post_rst_ready", 64'(src_ready_flat), 64'h3F);
    for (int c = 0; c < 2; c++) begin
      tick();
      check_output("post_rst_stale", 64'(cdb_valid_flat), 64'h0);
    end

    $display("[TB] single result");
    set_src(2, 1'b1, 4'd5, 16'h1234);
    tick();
    clear_srcs();
`ifndef CDB_BYPASS_EN
    check_output("single_early", 64'(cdb_valid_flat), 64'h0);
    tick();
`endif
    check_output("single_valid", 64'(cdb_valid_flat), 64'h8);
    check_output("single_tag", 64'(indices_flat), 64'h5000);
    check_output("single_data", new_values_flat, 64'h1234_0000_0000_0000);
    tick();
    check_output("single_once", 64'(cdb_valid_flat), 64'h0);
    check_output("single_tag_clr", 64'(indices_flat), 64'h0);

    $display("[TB] burst");
    do_flush();
    for (int k = 0; k < NS; k++) set_src(k, 1'b1, TW'(k), DW'(16'hA000 + k));
    tick();
    clear_srcs();
`ifndef CDB_BYPASS_EN
    check_output("burst_early", 64'(cdb_valid_flat), 64'h0);
    tick();
`endif
    check_output("burst1_valid", 64'(cdb_valid_flat), 64'hF);
    check_output("burst1_tags", 64'(indices_flat), 64'h0123);
    check_output("burst1_data", new_values_flat, 64'hA000_A001_A002_A003);
    tick();
    check_output("burst2_valid", 64'(cdb_valid_flat), 64'hC);
    check_output("burst2_tags", 64'(indices_flat), 64'h4500);
    check_output("burst2_data", new_values_flat, 64'hA004_A005_0000_0000);
    tick();
    check_output("burst_done", 64'(cdb_valid_flat), 64'h0);

    $display("[TB] fairness and backpressure");
    do_flush();
    for (int i = 1; i <= 9; i++) begin
      for (int k = 0; k < NS; k++) set_src(k, 1'b1, TW'(k), {4'(k), 12'(pushed[k])});
`ifndef CDB_BYPASS_EN
      check_output("fair_ready", 64'(src_ready_flat), 64'((i <= 2) ? 6'h3F : rdy_pat[(i-3)%3]));
`endif
      acc = src_ready_flat;
      tick();
      for (int k = 0; k < NS; k++) if (acc[NS-1-k]) pushed[k]++;
      score_slots();
`ifndef CDB_BYPASS_EN
      check_output("fair_valid", 64'(cdb_valid_flat), 64'((i == 1) ? 4'h0 : 4'hF));
      if (i >= 2) check_output("fair_rotation", 64'(indices_flat), 64'(idx_pat[(i-2)%3]));
`endif
    end
    clear_srcs();
    for (int c = 0; c < 8; c++) begin
      tick();
      score_slots();
    end
    for (int k = 0; k < NS; k++) check_output("fair_count", 64'(recv[k]), 64'(pushed[k]));
    check_output("fair_drained_ready", 64'(src_ready_flat), 64'h3F);
    check_output("fair_drained_valid", 64'(cdb_valid_flat), 64'h0);

    $display("[TB] flush with pending entries");
    for (int k = 0; k < 4; k++) set_src(k, 1'b1, TW'(8 + k), DW'(16'hF000 + k));
    tick();
    clear_srcs();
`ifndef CDB_BYPASS_EN
    check_output("flush_pending_quiet", 64'(cdb_valid_flat), 64'h0);
`endif
    flush = 1'b1;
    set_src(4, 1'b1, 4'd12, 16'hF004);
    tick();
    flush = 1'b0;
    clear_srcs();
    check_output("flush_valid", 64'(cdb_valid_flat), 64'h0);
    check_output("flush_tags", 64'(indices_flat), 64'h0);
    check_output("flush_ready", 64'(src_ready_flat), 64'h3F);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_output("flush_no_leak", 64'(cdb_valid_flat), 64'h0);
    end

    $display("[TB] reset mid-stream");
    for (int k = 0; k < NS; k++) set_src(k, 1'b1, TW'(k), DW'(16'hC000 + k));
    tick();
    clear_srcs();
    rst_n = 1'b0;
    tick();
    check_output("midrst_valid", 64'(cdb_valid_flat), 64'h0);
    check_output("midrst_values", new_values_flat, 64'h0);
    check_output("midrst_ready", 64'(src_ready_flat), 64'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check_output("midrst_no_leak", 64'(cdb_valid_flat), 64'h0);
    end
    check_output("midrst_ready_back", 64'(src_ready_flat), 64'h3F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
